fc_register_bank: RTL and testbench

//  Parametrised FC/UART register bank; next generation of the fixed SPI memory map.
//  N read-write control registers and M read-only status words, each mapped into an address window.
//  An atomic multi-word snapshot group prevents torn 64-bit time reads.
//  A sticky event register is cleared by writing 1s. Writes to bad addresses are counted.

---
 rtl/fc_regbank_pkg.sv | 28 ++
 rtl/fc_register_bank_if.sv | 24 ++
 rtl/fc_regbank_decode.sv | 42 ++++
 rtl/fc_register_bank.sv | 160 ++++++++++++++++
 tb/tb_fc_register_bank.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fc_regbank_pkg.sv
// Address map defaults, read fillers and named register indices for the FC register bank.
// Shared by the bank top, its address decoder and anything that talks to the bank.
package fc_regbank_pkg;

  localparam logic [15:0] RW_BASE           = 16'h0050;
  localparam logic [15:0] RO_BASE           = 16'h0001;
  localparam logic [15:0] STICKY_ADDR       = 16'h0020;
  localparam logic [15:0] ERR_ADDR          = 16'h0021;
  localparam logic [15:0] DEFAULT_RD        = 16'd123;
  localparam logic [15:0] IDLE_RD           = 16'd244;
  localparam logic [15:0] DEFAULT_THRESHOLD = 16'd2000;
  localparam logic [15:0] DBG_DEFAULT_RD    = 16'h1234;

  localparam int SYNC          = 0;
  localparam int SAMPLING_MODE = 1;
  localparam int THRESHOLD     = 2;
  localparam int CTRL4         = 3;
  localparam int REG5          = 4;

  typedef enum logic [2:0] {
    WIN_NONE,
    WIN_RW,
    WIN_RO,
    WIN_STICKY,
    WIN_ERR
  } win_e;

endpackage

// File: rtl/fc_register_bank_if.sv
// Write/read strobe bus between the SPI slave (master side) and the register bank (slave side).
// Reads have fixed 1-cycle latency and never stall; there is no backpressure.
interface fc_register_bank_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              wr_en_p;
  logic [ADDR_W-1:0] wr_addr_p;
  logic [DATA_W-1:0] wr_data_p;
  logic              rd_en_p;
  logic [ADDR_W-1:0] rd_addr_p;
  logic [DATA_W-1:0] rd_data_p;
  logic              rd_valid_p;

  modport master (
    output wr_en_p, wr_addr_p, wr_data_p, rd_en_p, rd_addr_p,
    input  rd_data_p, rd_valid_p
  );

  modport slave (
    input  wr_en_p, wr_addr_p, wr_data_p, rd_en_p, rd_addr_p,
    output rd_data_p, rd_valid_p
  );
endinterface

// File: rtl/fc_regbank_decode.sv
// Combinational address decoder: maps an address to a window and an index within it.
// Zero latency, no state; window ordering is guaranteed non-overlapping by the bank top.
module fc_regbank_decode
  import fc_regbank_pkg::*;
#(
  parameter int                ADDR_W    = 16,
  parameter int                IDX_W     = 3,
  parameter int                NUM_RW    = 8,
  parameter int                NUM_RO    = 8,
  parameter logic [ADDR_W-1:0] RW_START  = RW_BASE,
  parameter logic [ADDR_W-1:0] RO_START  = RO_BASE,
  parameter logic [ADDR_W-1:0] STICKY_AT = STICKY_ADDR,
  parameter logic [ADDR_W-1:0] ERR_AT    = ERR_ADDR
) (
  input  logic [ADDR_W-1:0] addr,
  output win_e              win,
  output logic [IDX_W-1:0]  idx
);

  logic [ADDR_W-1:0] rw_off;
  logic [ADDR_W-1:0] ro_off;

  assign rw_off = addr - RW_START;
  assign ro_off = addr - RO_START;

  always_comb begin
    win = WIN_NONE;
    idx = '0;
    if (addr >= RW_START && rw_off < ADDR_W'(NUM_RW)) begin
      win = WIN_RW;
      idx = rw_off[IDX_W-1:0];
    end else if (addr >= RO_START && ro_off < ADDR_W'(NUM_RO)) begin
      win = WIN_RO;
      idx = ro_off[IDX_W-1:0];
    end else if (addr == STICKY_AT) begin
      win = WIN_STICKY;
    end else if (addr == ERR_AT) begin
      win = WIN_ERR;
    end
  end

endmodule

// File: rtl/fc_register_bank.sv
// FC/UART register bank: RW controls, RO status with atomic snapshot, W1C sticky events, bad-write counter.
// Reads registered (1 cycle), never stall; optional debug read port under FC_REGBANK_DBG_PORT_EN.
module fc_register_bank #(
  parameter int                       DATA_W      = 16,
  parameter int                       ADDR_W      = 16,
  parameter int                       NUM_RW      = 8,
  parameter int                       NUM_RO      = 8,
  parameter logic [ADDR_W-1:0]        RW_BASE     = fc_regbank_pkg::RW_BASE,
  parameter logic [ADDR_W-1:0]        RO_BASE     = fc_regbank_pkg::RO_BASE,
  parameter logic [NUM_RW*DATA_W-1:0] RW_RST_VAL  = '0,
  parameter int                       SNAP_IDX    = 2,
  parameter int                       SNAP_LEN    = 4,
  parameter logic [ADDR_W-1:0]        STICKY_ADDR = fc_regbank_pkg::STICKY_ADDR,
  parameter logic [ADDR_W-1:0]        ERR_ADDR    = fc_regbank_pkg::ERR_ADDR,
  parameter logic [DATA_W-1:0]        DEFAULT_RD  = fc_regbank_pkg::DEFAULT_RD,
  parameter logic [DATA_W-1:0]        IDLE_RD     = fc_regbank_pkg::IDLE_RD
) (
  input  logic                     clk210_p,
  input  logic                     reset_p,
  fc_register_bank_if.slave        bus,
  input  logic [NUM_RO*DATA_W-1:0] ro_data_p,
  input  logic [DATA_W-1:0]        event_p,
  output logic [NUM_RW*DATA_W-1:0] rw_regs_p,
  output logic [NUM_RW-1:0]        wr_strobe_p,
  input  logic [ADDR_W-1:0]        dbg_rd_addr_p,
  output logic [DATA_W-1:0]        dbg_rd_data_p
);
  import fc_regbank_pkg::*;

  localparam int MAX_N = (NUM_RW > NUM_RO) ? NUM_RW : NUM_RO;
  localparam int IDX_W = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int SH_N  = (SNAP_LEN > 1) ? SNAP_LEN - 1 : 1;
  localparam int RW_LO = int'(RW_BASE);
  localparam int RW_HI = RW_LO + NUM_RW - 1;
  localparam int RO_LO = int'(RO_BASE);
  localparam int RO_HI = RO_LO + NUM_RO - 1;

  if (RW_LO <= RO_HI && RO_LO <= RW_HI) begin : g_chk_overlap
    $fatal(1, "fc_register_bank: read-write and read-only windows overlap");
  end
  if ((int'(STICKY_ADDR) >= RW_LO && int'(STICKY_ADDR) <= RW_HI) ||
      (int'(STICKY_ADDR) >= RO_LO && int'(STICKY_ADDR) <= RO_HI) ||
      (int'(ERR_ADDR) >= RW_LO && int'(ERR_ADDR) <= RW_HI) ||
      (int'(ERR_ADDR) >= RO_LO && int'(ERR_ADDR) <= RO_HI)) begin : g_chk_single
    $fatal(1, "fc_register_bank: sticky or error address inside a window");
  end
  if (SNAP_LEN < 1 || SNAP_IDX + SNAP_LEN > NUM_RO) begin : g_chk_snap
    $fatal(1, "fc_register_bank: snapshot group exceeds the read-only window");
  end

  logic [NUM_RW*DATA_W-1:0] rw_q;
  logic [SH_N*DATA_W-1:0]   shadow_q;
  logic [DATA_W-1:0]        sticky_q;
  logic [DATA_W-1:0]        err_cnt_q;
  logic [NUM_RW-1:0]        wr_strobe_q;

  win_e             wwin;
  win_e             rwin;
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;
  logic             snap_hit;

  fc_regbank_decode #(
    .ADDR_W(ADDR_W), .IDX_W(IDX_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO),
    .RW_START(RW_BASE), .RO_START(RO_BASE), .STICKY_AT(STICKY_ADDR), .ERR_AT(ERR_ADDR)
  ) u_wr_dec (
    .addr(bus.wr_addr_p), .win(wwin), .idx(widx)
  );

  fc_regbank_decode #(
    .ADDR_W(ADDR_W), .IDX_W(IDX_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO),
    .RW_START(RW_BASE), .RO_START(RO_BASE), .STICKY_AT(STICKY_ADDR), .ERR_AT(ERR_ADDR)
  ) u_rd_dec (
    .addr(bus.rd_addr_p), .win(rwin), .idx(ridx)
  );

  // Words after the group head come from the shadow captured when the head was read.
  function automatic logic [DATA_W-1:0] read_word(input win_e win, input logic [IDX_W-1:0] idx,
                                                  input logic use_shadow, input logic [DATA_W-1:0] miss);
    logic [DATA_W-1:0] word;
    word = miss;
    case (win)
      WIN_RW: word = rw_q[idx*DATA_W +: DATA_W];
      WIN_RO: begin
        word = ro_data_p[idx*DATA_W +: DATA_W];
        if (use_shadow && int'(idx) > SNAP_IDX && int'(idx) < SNAP_IDX + SNAP_LEN)
          word = shadow_q[(int'(idx) - SNAP_IDX - 1)*DATA_W +: DATA_W];
      end
      WIN_STICKY: word = sticky_q;
      WIN_ERR:    word = err_cnt_q;
      default:    word = miss;
    endcase
    return word;
  endfunction

  assign snap_hit    = bus.rd_en_p && (rwin == WIN_RO) && (int'(ridx) == SNAP_IDX);
  assign rw_regs_p   = rw_q;
  assign wr_strobe_p = wr_strobe_q;

  always_ff @(posedge clk210_p) begin
    if (reset_p) begin
      rw_q           <= RW_RST_VAL;
      sticky_q       <= '0;
      err_cnt_q      <= '0;
      wr_strobe_q    <= '0;
      bus.rd_valid_p <= 1'b0;
      bus.rd_data_p  <= '0;
    end else begin
      wr_strobe_q    <= '0;
      sticky_q       <= sticky_q | event_p;
      bus.rd_valid_p <= bus.rd_en_p;
      bus.rd_data_p  <= bus.rd_en_p ? read_word(rwin, ridx, 1'b1, DEFAULT_RD) : IDLE_RD;
      if (bus.wr_en_p) begin
        case (wwin)
          WIN_RW: begin
            rw_q[widx*DATA_W +: DATA_W] <= bus.wr_data_p;
            wr_strobe_q[widx]           <= 1'b1;
          end
          // An event arriving with the clear is kept: set wins.
          WIN_STICKY: sticky_q <= (sticky_q & ~bus.wr_data_p) | event_p;
          default: begin
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
          end
        endcase
      end
    end
  end

  if (SNAP_LEN > 1) begin : g_shadow
    always_ff @(posedge clk210_p) begin
      if (reset_p)       shadow_q <= '0;
      else if (snap_hit) shadow_q <= ro_data_p[(SNAP_IDX + 1)*DATA_W +: SH_N*DATA_W];
    end
  end else begin : g_no_shadow
    always_ff @(posedge clk210_p) shadow_q <= '0;
  end

`ifdef FC_REGBANK_DBG_PORT_EN
  win_e             dwin;
  logic [IDX_W-1:0] didx;

  fc_regbank_decode #(
    .ADDR_W(ADDR_W), .IDX_W(IDX_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO),
    .RW_START(RW_BASE), .RO_START(RO_BASE), .STICKY_AT(STICKY_ADDR), .ERR_AT(ERR_ADDR)
  ) u_dbg_dec (
    .addr(dbg_rd_addr_p), .win(dwin), .idx(didx)
  );

  // Debug reads must not disturb the snapshot, so they see live status words.
  always_ff @(posedge clk210_p) begin
    if (reset_p) dbg_rd_data_p <= '0;
    else         dbg_rd_data_p <= read_word(dwin, didx, 1'b0, DATA_W'(DBG_DEFAULT_RD));
  end
`else
  logic unused_dbg_addr;
  assign unused_dbg_addr = ^dbg_rd_addr_p;
  assign dbg_rd_data_p   = '0;
`endif

endmodule

// File: tb/tb_fc_register_bank.sv
// Randomised and directed stimulus against a behavioural register-map model; a negedge monitor
// pops per-cycle expectations and compares read data/valid, strobes, register contents and debug data.
module tb_fc_register_bank;
  import fc_regbank_pkg::*;

  localparam logic [127:0] RST_VAL = {16'h0, 16'h0, 16'h0, 16'h0, 16'h0,
                                      DEFAULT_THRESHOLD, 16'h0, 16'h0011};

  typedef struct {
    logic         vld;
    logic [15:0]  rd;
    logic [7:0]   stb;
    logic [127:0] regs;
    logic [15:0]  dbg;
  } exp_t;

  logic         clk210_p = 1'b0;
  logic         reset_p;
  logic [127:0] ro_data;
  logic [15:0]  event_p;
  logic [127:0] rw_regs;
  logic [7:0]   wr_strobe;
  logic [15:0]  dbg_addr;
  logic [15:0]  dbg_data;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [127:0] m_rw;
  logic [63:0]  m_shadow;
  logic [15:0]  m_sticky;
  logic [15:0]  m_err;

  fc_register_bank_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  fc_register_bank #(.RW_RST_VAL(RST_VAL)) dut (
    .clk210_p(clk210_p), .reset_p(reset_p), .bus(bus), .ro_data_p(ro_data),
    .event_p(event_p), .rw_regs_p(rw_regs), .wr_strobe_p(wr_strobe),
    .dbg_rd_addr_p(dbg_addr), .dbg_rd_data_p(dbg_data)
  );

  always #5 clk210_p = ~clk210_p;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  function automatic logic [15:0] ro_w(input int i);
    return ro_data[i*16 +: 16];
  endfunction

  // Address map: RW 0x50-0x57, RO 0x01-0x08 (snapshot head RO[2], tail RO[3..5]), 0x20, 0x21.
  function automatic logic [15:0] m_read(input logic [15:0] a, input bit snap, input logic [15:0] miss);
    int off;
    off = int'(a);
    if (off >= 'h50 && off <= 'h57) return m_rw[(off - 'h50)*16 +: 16];
    if (off >= 'h01 && off <= 'h08) begin
      off = off - 1;
      if (snap && off >= 3 && off <= 5) return m_shadow[(off - 2)*16 +: 16];
      return ro_w(off);
    end
    if (off == 'h20) return m_sticky;
    if (off == 'h21) return m_err;
    return miss;
  endfunction

  task automatic cycle(input bit rst, input bit we, input logic [15:0] wa, input logic [15:0] wd,
                       input bit re, input logic [15:0] ra, input logic [15:0] ev);
    exp_t e;
    int   woff;
    reset_p       = rst;
    bus.wr_en_p   = we;
    bus.wr_addr_p = wa;
    bus.wr_data_p = wd;
    bus.rd_en_p   = re;
    bus.rd_addr_p = ra;
    event_p       = ev;
    e.stb = '0;
`ifdef FC_REGBANK_DBG_PORT_EN
    e.dbg = m_read(dbg_addr, 1'b0, 16'h1234);
`else
    e.dbg = 16'h0;
`endif
    if (rst) begin
      e.vld = 1'b0; e.rd = 16'h0; e.dbg = 16'h0;
      m_rw = RST_VAL; m_shadow = '0; m_sticky = '0; m_err = '0;
    end else begin
      e.vld = re;
      e.rd  = re ? m_read(ra, 1'b1, 16'd123) : 16'd244;
      if (re && ra == 16'h0003)
        for (int k = 1; k <= 3; k++) m_shadow[k*16 +: 16] = ro_w(2 + k);
      woff = int'(wa);
      if (we && woff >= 'h50 && woff <= 'h57) begin
        m_rw[(woff - 'h50)*16 +: 16] = wd;
        e.stb = 8'(1 << (woff - 'h50));
        m_sticky = m_sticky | ev;
      end else if (we && wa == 16'h0020) begin
        m_sticky = (m_sticky & ~wd) | ev;
      end else begin
        if (we && m_err != 16'hFFFF) m_err = m_err + 16'd1;
        m_sticky = m_sticky | ev;
      end
    end
    e.regs = m_rw;
    @(posedge clk210_p);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic rd(input logic [15:0] a);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b1, a, 16'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic [15:0] ev);
    cycle(1'b0, 1'b1, a, d, 1'b0, 16'h0, ev);
  endtask

  always @(negedge clk210_p) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("rd_valid", bus.rd_valid_p, mon_e.vld);
      chk("rd_data", bus.rd_data_p, mon_e.rd);
      chk("wr_strobe", wr_strobe, mon_e.stb);
      chk("rw_regs", rw_regs, mon_e.regs);
      chk("dbg_rd_data", dbg_data, mon_e.dbg);
    end
  end

  initial begin
    logic [15:0] a;
    ro_data  = '0;
    dbg_addr = 16'h007F;
    m_rw = '0; m_shadow = '0; m_sticky = '0; m_err = '0;
    @(posedge clk210_p);
    #1;
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    // threshold reset value, then write visibility on the same and next cycle
    rd(16'h0052);
    cycle(1'b0, 1'b1, 16'h0051, 16'hA5A5, 1'b1, 16'h0051, 16'h0);
    rd(16'h0051);
    // snapshot group must not tear when the time rolls over
    ro_data[2*16 +: 64] = 64'hFFFF_0003_0002_0001;
    rd(16'h0003);
    ro_data[2*16 +: 64] = 64'h0000_0004_0002_0001;
    rd(16'h0004);
    rd(16'h0005);
    rd(16'h0006);
    rd(16'h0003);
    rd(16'h0006);
    // sticky set beats same-cycle clear
    wr(16'h0000, 16'h0, 16'h0005);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0005);
    wr(16'h0020, 16'h0001, 16'h0001);
    rd(16'h0020);
    wr(16'h0020, 16'h0004, 16'h0);
    rd(16'h0020);
    // bad writes, unmapped and idle reads
    wr(16'h0002, 16'h1111, 16'h0);
    wr(16'h007F, 16'h2222, 16'h0);
    rd(16'h0021);
    rd(16'h007F);
    cycle(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    // reset after and during a read
    rd(16'h0052);
    cycle(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
    cycle(1'b1, 1'b1, 16'h0053, 16'h7777, 1'b1, 16'h0052, 16'h00FF);
    rd(16'h0051);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) ro_data[$urandom_range(0, 7)*16 +: 16] = 16'($urandom);
      dbg_addr = (i % 3 == 0) ? 16'($urandom_range(0, 'h5F)) : dbg_addr;
      case ($urandom_range(0, 5))
        0: a = 16'h0050 + 16'($urandom_range(0, 7));
        1: a = 16'h0001 + 16'($urandom_range(0, 7));
        2: a = 16'h0003 + 16'($urandom_range(0, 3));
        3: a = 16'h0020 + 16'($urandom_range(0, 1));
        4: a = 16'($urandom_range(0, 'h60));
        default: a = 16'($urandom);
      endcase
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 1) == 1) ? a : 16'h0050 + 16'($urandom_range(0, 7)),
            16'($urandom), $urandom_range(0, 2) != 0, a,
            ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0);
    end
    bus.wr_en_p = 1'b0;
    bus.rd_en_p = 1'b0;
    for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk210_p);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
